// File: rtl/axi_pkg.sv
// Shared AXI4 encodings and field types for the slave memory block.
package axi_pkg;

  typedef logic [7:0] len_t;
  typedef logic [2:0] size_t;
  typedef logic [1:0] burst_t;
  typedef logic [1:0] resp_t;

  localparam resp_t OKAY   = 2'b00;
  localparam resp_t EXOKAY = 2'b01;
  localparam resp_t SLVERR = 2'b10;
  localparam resp_t DECERR = 2'b11;

  localparam burst_t FIXED = 2'b00;
  localparam burst_t INCR  = 2'b01;
  localparam burst_t WRAP  = 2'b10;

  // The encoding order of OKAY, SLVERR and DECERR already matches their severity
  function automatic resp_t resp_worst(input resp_t a, input resp_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi_slave_mem_if.sv
// AXI4 bus bundle between a master and the slave memory.
interface axi_slave_mem_if #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  import axi_pkg::*;

  logic [ID_W-1:0]     AWID;
  logic [ADDR_W-1:0]   AWADDR;
  len_t                AWLEN;
  size_t               AWSIZE;
  burst_t              AWBURST;
  logic                AWVALID;
  logic                AWREADY;

  logic [DATA_W-1:0]   WDATA;
  logic [DATA_W/8-1:0] WSTRB;
  logic                WLAST;
  logic                WVALID;
  logic                WREADY;

  logic [ID_W-1:0]     BID;
  resp_t               BRESP;
  logic                BVALID;
  logic                BREADY;

  logic [ID_W-1:0]     ARID;
  logic [ADDR_W-1:0]   ARADDR;
  len_t                ARLEN;
  size_t               ARSIZE;
  burst_t              ARBURST;
  logic                ARVALID;
  logic                ARREADY;

  logic [ID_W-1:0]     RID;
  logic [DATA_W-1:0]   RDATA;
  resp_t               RRESP;
  logic                RLAST;
  logic                RVALID;
  logic                RREADY;

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, input AWREADY,
    output WDATA, WSTRB, WLAST, WVALID, input WREADY,
    input BID, BRESP, BVALID, output BREADY,
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, input ARREADY,
    input RID, RDATA, RRESP, RLAST, RVALID, output RREADY
  );

  modport slave (
    input AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, output AWREADY,
    input WDATA, WSTRB, WLAST, WVALID, output WREADY,
    output BID, BRESP, BVALID, input BREADY,
    input ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID, input RREADY
  );

endinterface

// File: rtl/axi_slave_mem_ram.sv
// Word-organised storage: byte-strobed write port, registered read port.
module axi_slave_mem_ram #(
  parameter int DATA_W    = 64,
  parameter int MEM_WORDS = 256
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [$clog2(MEM_WORDS)-1:0] waddr,
  input  logic [DATA_W/8-1:0]          wstrb,
  input  logic [DATA_W-1:0]            wdata,
  input  logic                         re,
  input  logic [$clog2(MEM_WORDS)-1:0] raddr,
  output logic [DATA_W-1:0]            rdata
);

  logic [DATA_W-1:0] mem [MEM_WORDS];

  // A same-cycle read of the word being written returns the old contents
  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned b = 0; b < DATA_W/8; b++) begin
        if (wstrb[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/axi_slave_mem.sv
// AXI4 slave memory: independent write (AW/W/B) and read (AR/R) state machines.
module axi_slave_mem
  import axi_pkg::*;
#(
  parameter int ID_W      = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int MEM_WORDS = 256
) (
  input  logic            ACLK,
  input  logic            ARESET,
  axi_slave_mem_if.slave  axi
);

  localparam int OFF   = $clog2(DATA_W/8);
  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int XA_W  = ADDR_W + 1;

  // One spare top bit so an INCR step past the address space stays out of range
  typedef logic [XA_W-1:0] xaddr_t;
  localparam xaddr_t STEP      = xaddr_t'(DATA_W/8);
  localparam size_t  FULL_SIZE = size_t'(OFF);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  function automatic logic burst_bad(input size_t s, input burst_t b);
    return (s != FULL_SIZE) || ((b != FIXED) && (b != INCR));
  endfunction

  function automatic resp_t beat_resp(input xaddr_t a, input logic berr);
    if ((a >> (OFF + IDX_W)) != '0) return DECERR;
    if (berr) return SLVERR;
    return OKAY;
  endfunction

  // Write path
  wstate_t         w_state;
  logic            awready, wready, bvalid;
  logic [ID_W-1:0] bid;
  resp_t           bresp, w_acc;
  xaddr_t          w_addr;
  len_t            w_len, w_beat;
  logic            w_fixed, w_berr;

  logic   w_hs, w_last, ram_we;
  resp_t  w_beat_resp, w_acc_next;
  xaddr_t w_addr_next;

  always_comb begin
    w_hs        = axi.WVALID && wready;
    w_last      = (w_beat == w_len);
    w_beat_resp = beat_resp(w_addr, w_berr);
    w_acc_next  = resp_worst(resp_worst(w_acc, w_beat_resp),
                             (axi.WLAST != w_last) ? SLVERR : OKAY);
    ram_we      = w_hs && (w_beat_resp == OKAY);
    w_addr_next = w_fixed ? w_addr : w_addr + STEP;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state <= W_IDLE;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bid     <= '0;
      bresp   <= OKAY;
      w_acc   <= OKAY;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (axi.AWVALID && awready) begin
            awready <= 1'b0;
            wready  <= 1'b1;
            bid     <= axi.AWID;
            w_addr  <= {1'b0, axi.AWADDR};
            w_len   <= axi.AWLEN;
            w_beat  <= '0;
            w_fixed <= (axi.AWBURST == FIXED);
            w_berr  <= burst_bad(axi.AWSIZE, axi.AWBURST);
            w_acc   <= OKAY;
            w_state <= W_DATA;
          end else begin
            awready <= 1'b1;
          end
        end
        // Beat count alone ends the burst; WLAST only feeds the response
        W_DATA: begin
          if (w_hs) begin
            if (w_last) begin
              wready  <= 1'b0;
              bvalid  <= 1'b1;
              bresp   <= w_acc_next;
              w_state <= W_RESP;
            end else begin
              w_beat <= w_beat + 1'b1;
              w_addr <= w_addr_next;
              w_acc  <= w_acc_next;
            end
          end
        end
        W_RESP: begin
          if (axi.BREADY) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read path
  rstate_t         r_state;
  logic            arready, rvalid, rlast, r_ok;
  logic [ID_W-1:0] rid;
  resp_t           rresp;
  xaddr_t          r_addr;
  len_t            r_len, r_beat;
  logic            r_fixed, r_berr;

  logic              ar_hs, r_hs, ar_berr, ram_re;
  xaddr_t            ar_xaddr, r_addr_next;
  resp_t             ar_resp, rn_resp;
  logic [IDX_W-1:0]  ram_raddr;
  logic [DATA_W-1:0] ram_rdata;

  // RAM is read on the handshake edge itself so the next beat appears with no bubble
  always_comb begin
    ar_hs       = axi.ARVALID && arready;
    r_hs        = rvalid && axi.RREADY;
    ar_xaddr    = {1'b0, axi.ARADDR};
    ar_berr     = burst_bad(axi.ARSIZE, axi.ARBURST);
    ar_resp     = beat_resp(ar_xaddr, ar_berr);
    r_addr_next = r_fixed ? r_addr : r_addr + STEP;
    rn_resp     = beat_resp(r_addr_next, r_berr);
    ram_re      = ar_hs || (r_hs && !rlast);
    ram_raddr   = ar_hs ? ar_xaddr[OFF +: IDX_W] : r_addr_next[OFF +: IDX_W];
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state <= R_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rid     <= '0;
      rresp   <= OKAY;
      r_ok    <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            arready <= 1'b0;
            rvalid  <= 1'b1;
            rlast   <= (axi.ARLEN == 8'd0);
            rid     <= axi.ARID;
            rresp   <= ar_resp;
            r_ok    <= (ar_resp == OKAY);
            r_addr  <= ar_xaddr;
            r_len   <= axi.ARLEN;
            r_beat  <= '0;
            r_fixed <= (axi.ARBURST == FIXED);
            r_berr  <= ar_berr;
            r_state <= R_DATA;
          end else begin
            arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (r_hs) begin
            if (rlast) begin
              rvalid  <= 1'b0;
              rlast   <= 1'b0;
              arready <= 1'b1;
              r_state <= R_IDLE;
            end else begin
              r_beat <= r_beat + 1'b1;
              r_addr <= r_addr_next;
              rlast  <= (len_t'(r_beat + 1'b1) == r_len);
              rresp  <= rn_resp;
              r_ok   <= (rn_resp == OKAY);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  axi_slave_mem_ram #(
    .DATA_W    (DATA_W),
    .MEM_WORDS (MEM_WORDS)
  ) u_ram (
    .clk   (ACLK),
    .we    (ram_we),
    .waddr (w_addr[OFF +: IDX_W]),
    .wstrb (axi.WSTRB),
    .wdata (axi.WDATA),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  assign axi.AWREADY = awready;
  assign axi.WREADY  = wready;
  assign axi.BID     = bid;
  assign axi.BRESP   = bresp;
  assign axi.BVALID  = bvalid;
  assign axi.ARREADY = arready;
  assign axi.RID     = rid;
  assign axi.RDATA   = r_ok ? ram_rdata : '0;
  assign axi.RRESP   = rresp;
  assign axi.RLAST   = rlast;
  assign axi.RVALID  = rvalid;

endmodule
